decode_issue_ctrl: RTL and testbench

//  Decode-stage issue controller between instruction fetch (cached memory port) and execute.
//  - Buffers fetched instructions in a 2-entry skid buffer with valid/ready handshakes on both sides.
//  - Decodes opcode[6:0], builds the I/S/B/U/J immediates and selects one into a registered out_imm.
//  - Flags illegal opcodes; flush discards in-flight entries; counts back-pressure stall cycles.

---
 rtl/decode_issue_ctrl.sv | 138 +++++++++++++
 tb/tb_decode_issue_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: 2-entry skid-buffered decode stage with immediate select,
// illegal-opcode flag, flush, and a saturating back-pressure stall counter.
`default_nettype none

module decode_issue_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        illegal;
  } entry_t;

  state_e           state_q, state_d;
  entry_t           main_q, main_d, skid_q, skid_d;
  entry_t           new_entry;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             in_fire, out_fire;
  logic [31:0]      imm_i, imm_s, imm_b, imm_u, imm_j;

  // Decode happens on the way in so imm/illegal travel with the entry.
  always_comb begin
    imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
             in_instr[11:8], 1'b0};
    imm_u = {in_instr[31:12], 12'b0};
    imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
             in_instr[30:21], 1'b0};

    new_entry.instr   = in_instr;
    new_entry.pc      = in_pc;
    new_entry.imm     = 32'd0;
    new_entry.illegal = 1'b0;
    case (in_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: new_entry.imm = imm_i;
      7'b0100011:                         new_entry.imm = imm_s;
      7'b1100011:                         new_entry.imm = imm_b;
      7'b1101111:                         new_entry.imm = imm_j;
      7'b0010111, 7'b0110111:             new_entry.imm = imm_u;
      7'b0110011:                         new_entry.imm = 32'd0;
      default:                            new_entry.illegal = 1'b1;
    endcase
  end

  assign in_ready     = (state_q != FULL);
  assign out_valid    = (state_q != EMPTY);
  assign out_instr    = main_q.instr;
  assign out_pc       = main_q.pc;
  assign out_imm      = main_q.imm;
  assign out_illegal  = main_q.illegal;
  assign stall_cycles = stall_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = new_entry;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = new_entry;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = new_entry;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_issue_ctrl.sv
// tb_decode_issue_ctrl: randomized + directed stimulus with a queue-based
// reference model; a negedge monitor pops and compares every issued beat.
`default_nettype none

module tb_decode_issue_ctrl;

  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_instr = '0;
  logic [31:0]      in_pc = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_instr, out_pc, out_imm;
  logic             out_illegal;
  logic [CNT_W-1:0] stall_cycles;

  decode_issue_ctrl #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_imm(out_imm), .out_illegal(out_illegal),
    .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          passes = 0;
  int          stall_m = 0;
  logic        rec_fire = 1'b0, rec_flush = 1'b0;
  logic [31:0] rec_instr = '0, rec_pc = '0;
  logic        hold_prev = 1'b0;
  logic [31:0] prev_instr = '0, prev_imm = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference decode: immediates built with arithmetic shifts and masks.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
    exp_t        e;
    int          s, t;
    logic [31:0] u, sg;
    s = int'(i);
    u = i;
    e.instr = i;
    e.pc    = pc;
    e.imm   = 32'd0;
    e.ill   = 1'b0;
    case (u & 32'h7F)
      32'h13, 32'h03, 32'h67: begin t = s >>> 20; e.imm = t; end
      32'h23: begin
        t = s >>> 25; sg = t;
        e.imm = (sg << 5) | ((u >> 7) & 32'h1F);
      end
      32'h63: begin
        t = s >>> 31; sg = t;
        e.imm = (sg << 12) | (((u >> 7) & 32'h1) << 11) | (((u >> 25) & 32'h3F) << 5)
              | (((u >> 8) & 32'hF) << 1);
      end
      32'h6F: begin
        t = s >>> 31; sg = t;
        e.imm = (sg << 20) | (u & 32'h000FF000) | (((u >> 20) & 32'h1) << 11)
              | (((u >> 21) & 32'h3FF) << 1);
      end
      32'h17, 32'h37: e.imm = u & 32'hFFFFF000;
      32'h33:         e.imm = 32'd0;
      default:        e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // One clock of stimulus. The previous cycle's transfer is committed to the
  // model just after the edge, then new inputs go out, then handshake is checked.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic fl, input logic ordy);
    @(posedge clock);
    #1;
    if (rec_flush) q.delete();
    else if (rec_fire) q.push_back(model(rec_instr, rec_pc));
    rec_fire  = 1'b0;
    rec_flush = 1'b0;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    flush     = fl;
    out_ready = ordy;
    #3;
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    rec_fire  = v && in_ready;
    rec_flush = fl;
    rec_instr = ins;
    rec_pc    = pc;
  endtask

  always @(negedge clock) begin
    if (reset) begin
      chk("stall_cycles", 32'(stall_cycles), stall_m);
      if (hold_prev && out_valid) begin
        chk("hold_instr", out_instr, prev_instr);
        chk("hold_imm", out_imm, prev_imm);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", out_instr, 32'hDEAD_BEEF);
        end else begin
          chk("out_instr", out_instr, q[0].instr);
          chk("out_pc", out_pc, q[0].pc);
          chk("out_imm", out_imm, q[0].imm);
          chk("out_illegal", {31'd0, out_illegal}, {31'd0, q[0].ill});
          void'(q.pop_front());
        end
      end
      if (q.size() != 0 && !out_ready && stall_m < (1 << CNT_W) - 1) stall_m++;
      hold_prev  = out_valid && !out_ready;
      prev_instr = out_instr;
      prev_imm   = out_imm;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [6:0]  ops [12] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F,
                            7'h17, 7'h37, 7'h33, 7'h73, 7'h00, 7'h7F};
  logic [31:0] dir [6]  = '{32'h00500093, 32'hFFF00113, 32'hFE000EE3,
                            32'h8000006F, 32'h123450B7, 32'h00112623};

  initial begin
    logic [31:0] r;
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_imm", out_imm, 32'd0);
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    reset = 1'b1;

    // Directed decode stream, back-to-back with execute always ready.
    foreach (dir[k]) cyc(1'b1, dir[k], 32'h1000 + 32'(k) * 4, 1'b0, 1'b1);
    cyc(1'b1, 32'h00000073, 32'h2000, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);

    // Back-pressure: three pushes, only two fit; then release.
    cyc(1'b1, 32'h00A00093, 32'h3000, 1'b0, 1'b0);
    cyc(1'b1, 32'h00B00093, 32'h3004, 1'b0, 1'b0);
    cyc(1'b1, 32'h00C00093, 32'h3008, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);

    // Flush while FULL, then flush in ONE with simultaneous in_fire and out_fire.
    cyc(1'b1, 32'h00100093, 32'h4000, 1'b0, 1'b0);
    cyc(1'b1, 32'h00200093, 32'h4004, 1'b0, 1'b0);
    cyc(1'b1, 32'h00300093, 32'h4008, 1'b1, 1'b0);
    cyc(1'b1, 32'h00400093, 32'h400C, 1'b0, 1'b0);
    cyc(1'b1, 32'h00500093, 32'h4010, 1'b1, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a cycle while FULL.
    cyc(1'b1, 32'h00600093, 32'h5000, 1'b0, 1'b0);
    cyc(1'b1, 32'h00700093, 32'h5004, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clock);
    #2;
    reset     = 1'b0;
    in_valid  = 1'b0;
    #1;
    chk("amid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("amid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("amid_rst_stall", 32'(stall_cycles), 32'd0);
    q.delete();
    stall_m   = 0;
    hold_prev = 1'b0;
    rec_fire  = 1'b0;
    rec_flush = 1'b0;
    #3;
    reset = 1'b1;

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      cyc(($urandom_range(3) != 0), {r[31:7], ops[$urandom_range(11)]}, $urandom(),
          ($urandom_range(19) == 0), ($urandom_range(2) != 0));
    end

    for (int n = 0; n < 20 && (q.size() != 0 || rec_fire); n++)
      cyc(1'b0, '0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
